// File: rtl/expmul_row_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : expmul_row_ctrl_pkg
// Purpose : Shared types for the expmul row sequencer: score format, O*/V*
//           vector element and vector types, and the controller state enum.
// Config  : EXPMUL_CTRL_SAT_EN (consumed by star_vec_add, not by this package)
// Rev     : 1.0  initial release
// ============================================================================
package expmul_row_ctrl_pkg;

    localparam int MAX_EMBEDDING_DIM = 3;
    localparam int DIM               = MAX_EMBEDDING_DIM + 1;
    localparam int ELEM_W            = 27;

    // Score / max values: signed Q4.4 in 9 bits.
    typedef logic signed [8:0] EXPMUL_DIFF_IN_QT;

    // One O*/V* element: signed Q9.17.
    typedef logic signed [ELEM_W-1:0] STAR_ELEM_T;

    typedef STAR_ELEM_T [DIM-1:0] STAR_VECTOR_T;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } EXPMUL_CTRL_STATE_T;

    // Signed max; a tie returns the running value a.
    function automatic EXPMUL_DIFF_IN_QT qt_max(input EXPMUL_DIFF_IN_QT a,
                                                input EXPMUL_DIFF_IN_QT b);
        return (b > a) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/expmul_row_ctrl_star_vec_add.sv
`default_nettype none
// ============================================================================
// Module  : star_vec_add
// Purpose : Combinational DIM-wide element adder folding the scaled O* and
//           scaled V* vectors into the new O* accumulator.
// Ports   : i_a, i_b  operand vectors
//           o_sum     element-wise sum
// Config  : EXPMUL_CTRL_SAT_EN defined   -> each element saturates to
//                                           [-2^26, 2^26-1]
//           EXPMUL_CTRL_SAT_EN undefined -> two's-complement wrap
// Rev     : 1.0  initial release
// ============================================================================
module star_vec_add
    import expmul_row_ctrl_pkg::*;
(
    input  STAR_VECTOR_T i_a,
    input  STAR_VECTOR_T i_b,
    output STAR_VECTOR_T o_sum
);

    for (genvar gi = 0; gi < DIM; gi++) begin : g_elem
`ifdef EXPMUL_CTRL_SAT_EN
        localparam STAR_ELEM_T ELEM_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
        localparam STAR_ELEM_T ELEM_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

        logic [ELEM_W:0] w_wide;

        assign w_wide = {i_a[gi][ELEM_W-1], i_a[gi]} + {i_b[gi][ELEM_W-1], i_b[gi]};

        // Overflow shows as the two top bits of the widened sum disagreeing;
        // the extra top bit then carries the true sign.
        assign o_sum[gi] = (w_wide[ELEM_W] != w_wide[ELEM_W-1])
                         ? (w_wide[ELEM_W] ? ELEM_MIN : ELEM_MAX)
                         : STAR_ELEM_T'(w_wide[ELEM_W-1:0]);
`else
        assign o_sum[gi] = i_a[gi] + i_b[gi];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/expmul_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : expmul_row_ctrl
// Purpose : Row sequencer for the expmul datapath. Takes one (s, V*) pair per
//           key, tracks the running max, issues one expmul transaction per
//           key, folds exp_o + exp_v into the O* accumulator and presents the
//           finished row (O*, max, key count) to normalisation.
// Ports   : clk, rst_n                          clock, async active-low reset
//           s_vld_in/s_rdy_out, s_in, v_star_in, last_in   key input
//           em_vld_out/em_rdy_in, em_m_out, em_m_prev_out, em_s_out,
//           em_o_star_prev_out, em_v_star_out   request to expmul
//           em_vld_in/em_rdy_out, em_exp_o_in, em_exp_v_in result from expmul
//           o_vld_out/o_rdy_in, o_star_out, m_out, n_keys_out  row result
// Config  : EXPMUL_CTRL_SAT_EN selects saturating accumulator adds
// Rev     : 1.0  initial release
// ============================================================================
module expmul_row_ctrl
    import expmul_row_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_vld_in,
    output logic             s_rdy_out,
    input  EXPMUL_DIFF_IN_QT s_in,
    input  STAR_VECTOR_T     v_star_in,
    input  logic             last_in,
    output logic             em_vld_out,
    input  logic             em_rdy_in,
    output EXPMUL_DIFF_IN_QT em_m_out,
    output EXPMUL_DIFF_IN_QT em_m_prev_out,
    output EXPMUL_DIFF_IN_QT em_s_out,
    output STAR_VECTOR_T     em_o_star_prev_out,
    output STAR_VECTOR_T     em_v_star_out,
    input  logic             em_vld_in,
    output logic             em_rdy_out,
    input  STAR_VECTOR_T     em_exp_o_in,
    input  STAR_VECTOR_T     em_exp_v_in,
    output logic             o_vld_out,
    input  logic             o_rdy_in,
    output STAR_VECTOR_T     o_star_out,
    output EXPMUL_DIFF_IN_QT m_out,
    output logic [CNT_W-1:0] n_keys_out
);

    EXPMUL_CTRL_STATE_T r_state;
    EXPMUL_CTRL_STATE_T w_state_nxt;

    logic             r_first;
    logic             r_last;
    EXPMUL_DIFF_IN_QT r_s;
    EXPMUL_DIFF_IN_QT r_m;
    EXPMUL_DIFF_IN_QT r_m_prev;
    STAR_VECTOR_T     r_v;
    STAR_VECTOR_T     r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic r_s_rdy;
    logic r_em_vld;
    logic r_em_rdy;
    logic r_o_vld;

    logic             w_key_acc;
    logic             w_rsp_acc;
    logic             w_row_acc;
    EXPMUL_DIFF_IN_QT w_m_prev_eff;
    STAR_VECTOR_T     w_sum;

    assign w_key_acc = (r_state == IDLE) && s_vld_in;
    assign w_rsp_acc = (r_state == WAIT) && em_vld_in;
    assign w_row_acc = (r_state == DONE) && o_rdy_in;

    // On the first key of a row the running max is seeded with the score
    // itself, so m = m_prev = s.
    assign w_m_prev_eff = r_first ? s_in : r_m_prev;

    star_vec_add u_add (
        .i_a   (em_exp_o_in),
        .i_b   (em_exp_v_in),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (s_vld_in)  w_state_nxt = ISSUE;
            ISSUE:   if (em_rdy_in) w_state_nxt = WAIT;
            WAIT:    if (em_vld_in) w_state_nxt = r_last ? DONE : IDLE;
            DONE:    if (o_rdy_in)  w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode so no
    // input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_rdy  <= 1'b1;
            r_em_vld <= 1'b0;
            r_em_rdy <= 1'b0;
            r_o_vld  <= 1'b0;
        end else begin
            r_s_rdy  <= (w_state_nxt == IDLE);
            r_em_vld <= (w_state_nxt == ISSUE);
            r_em_rdy <= (w_state_nxt == WAIT);
            r_o_vld  <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first  <= 1'b1;
            r_last   <= 1'b0;
            r_s      <= '0;
            r_m      <= '0;
            r_m_prev <= '0;
            r_v      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_key_acc) begin
                r_s      <= s_in;
                r_v      <= v_star_in;
                r_last   <= last_in;
                r_m      <= qt_max(w_m_prev_eff, s_in);
                r_m_prev <= w_m_prev_eff;
                if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_rsp_acc) begin
                r_acc    <= w_sum;
                r_m_prev <= r_m;
                r_first  <= 1'b0;
            end
            if (w_row_acc) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_first <= 1'b1;
            end
        end
    end

    assign s_rdy_out          = r_s_rdy;
    assign em_vld_out         = r_em_vld;
    assign em_rdy_out         = r_em_rdy;
    assign o_vld_out          = r_o_vld;
    assign em_m_out           = r_m;
    assign em_m_prev_out      = r_m_prev;
    assign em_s_out           = r_s;
    assign em_o_star_prev_out = r_acc;
    assign em_v_star_out      = r_v;
    assign o_star_out         = r_acc;
    assign m_out              = r_m;
    assign n_keys_out         = r_cnt;

endmodule
`default_nettype wire
